// File: rtl/reg_bus_arbiter_if.sv
// reg_bus_arbiter_if: bundles the two host request ports and the register-bank
// port of reg_bus_arbiter.
//   m0_* / m1_*         : request/response channel of port 0 (UART) / port 1 (I2C)
//   address, data_write_to_reg, reg_en, write_en : arbiter -> register bank
//   data_read_from_reg  : register bank -> arbiter
// Modports:
//   master : the host/bank side (drives requests and bank read data)
//   slave  : the arbiter side
interface reg_bus_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          m0_valid;
  logic          m0_ready;
  logic          m0_write;
  logic          m0_lock;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_rsp_valid;
  logic [DW-1:0] m0_rdata;

  logic          m1_valid;
  logic          m1_ready;
  logic          m1_write;
  logic          m1_lock;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_rsp_valid;
  logic [DW-1:0] m1_rdata;

  logic [AW-1:0] address;
  logic [DW-1:0] data_write_to_reg;
  logic [DW-1:0] data_read_from_reg;
  logic          reg_en;
  logic          write_en;

  modport master (
    output m0_valid, m0_write, m0_lock, m0_addr, m0_wdata,
    input  m0_ready, m0_rsp_valid, m0_rdata,
    output m1_valid, m1_write, m1_lock, m1_addr, m1_wdata,
    input  m1_ready, m1_rsp_valid, m1_rdata,
    input  address, data_write_to_reg, reg_en, write_en,
    output data_read_from_reg
  );

  modport slave (
    input  m0_valid, m0_write, m0_lock, m0_addr, m0_wdata,
    output m0_ready, m0_rsp_valid, m0_rdata,
    input  m1_valid, m1_write, m1_lock, m1_addr, m1_wdata,
    output m1_ready, m1_rsp_valid, m1_rdata,
    output address, data_write_to_reg, reg_en, write_en,
    input  data_read_from_reg
  );
endinterface

// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: shares one register-bank port between two bus masters
// (port 0 = UART host interface, port 1 = I2C host interface).
// Round-robin arbitration with an optional bounded lock for block transfers;
// reads wait RD_LAT cycles for bank data and return it with a 1-cycle strobe.
// Ports:
//   clk     : system clock
//   resetb  : asynchronous active-low reset
//   bus     : reg_bus_arbiter_if.slave (host request ports + bank port)
//   m0_grant_cnt, m1_grant_cnt, contention_cnt : 16-bit saturating statistics,
//             present only when REG_ARB_STATS_EN is defined
// Optional feature macro: REG_ARB_STATS_EN
module reg_bus_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int RD_LAT   = 1,
  parameter int MAX_LOCK = 16
) (
  input  logic              clk,
  input  logic              resetb,
  reg_bus_arbiter_if.slave  bus
`ifdef REG_ARB_STATS_EN
  ,
  output logic [15:0]       m0_grant_cnt,
  output logic [15:0]       m1_grant_cnt,
  output logic [15:0]       contention_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam logic [7:0] LOCK_MAX  = 8'(MAX_LOCK);
  localparam logic [2:0] WAIT_INIT = 3'(RD_LAT - 1);

  state_t        state;
  logic          last_grant;
  logic          owner;
  logic [7:0]    lock_cnt;
  logic [2:0]    wait_cnt;
  logic          lat_write;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;

  logic          own_valid;
  logic          own_lock;
  logic          other_valid;
  logic          pick;
  logic [7:0]    next_lock;
  logic          any_valid;

  assign any_valid = bus.m0_valid | bus.m1_valid;

  // Winner selection for an IDLE cycle. "Owner" is the port of the previous
  // grant; it keeps the bus while locked, until LOCK_MAX locked grants have
  // been given and the other port is waiting.
  always_comb begin
    own_valid   = last_grant ? bus.m1_valid : bus.m0_valid;
    own_lock    = last_grant ? bus.m1_lock  : bus.m0_lock;
    other_valid = last_grant ? bus.m0_valid : bus.m1_valid;
    pick        = last_grant;
    next_lock   = '0;
    if (own_valid && own_lock && (lock_cnt < LOCK_MAX)) begin
      pick      = last_grant;
      next_lock = lock_cnt + 8'd1;
    end else if (own_valid && own_lock && !other_valid) begin
      pick      = last_grant;
      next_lock = lock_cnt;
    end else if (other_valid) begin
      pick      = ~last_grant;
      next_lock = '0;
    end else begin
      pick      = last_grant;
      next_lock = '0;
    end
  end

  // All outputs are registered, so each state's outputs appear in the cycle
  // after that state: ready follows IDLE, reg_en follows ISSUE, and the read
  // data is sampled on the edge leaving RESP, i.e. RD_LAT cycles after the
  // reg_en cycle, which gives ready -> rsp_valid = RD_LAT + 2.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state                 <= IDLE;
      last_grant            <= 1'b1;
      owner                 <= 1'b0;
      lock_cnt              <= '0;
      wait_cnt              <= '0;
      lat_write             <= 1'b0;
      lat_addr              <= '0;
      lat_wdata             <= '0;
      bus.m0_ready          <= 1'b0;
      bus.m1_ready          <= 1'b0;
      bus.m0_rsp_valid      <= 1'b0;
      bus.m1_rsp_valid      <= 1'b0;
      bus.m0_rdata          <= '0;
      bus.m1_rdata          <= '0;
      bus.address           <= '0;
      bus.data_write_to_reg <= '0;
      bus.reg_en            <= 1'b0;
      bus.write_en          <= 1'b0;
    end else begin
      bus.m0_ready     <= 1'b0;
      bus.m1_ready     <= 1'b0;
      bus.m0_rsp_valid <= 1'b0;
      bus.m1_rsp_valid <= 1'b0;
      bus.reg_en       <= 1'b0;
      bus.write_en     <= 1'b0;
      case (state)
        IDLE: begin
          if (any_valid) begin
            if (pick) bus.m1_ready <= 1'b1;
            else      bus.m0_ready <= 1'b1;
            owner      <= pick;
            last_grant <= pick;
            lock_cnt   <= next_lock;
            lat_write  <= pick ? bus.m1_write : bus.m0_write;
            lat_addr   <= pick ? bus.m1_addr  : bus.m0_addr;
            lat_wdata  <= pick ? bus.m1_wdata : bus.m0_wdata;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          bus.address           <= lat_addr;
          bus.data_write_to_reg <= lat_wdata;
          bus.reg_en            <= 1'b1;
          bus.write_en          <= lat_write;
          if (lat_write) begin
            state <= IDLE;
          end else begin
            wait_cnt <= WAIT_INIT;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == '0) state <= RESP;
          else                wait_cnt <= wait_cnt - 3'd1;
        end
        RESP: begin
          if (owner) begin
            bus.m1_rdata     <= bus.data_read_from_reg;
            bus.m1_rsp_valid <= 1'b1;
          end else begin
            bus.m0_rdata     <= bus.data_read_from_reg;
            bus.m0_rsp_valid <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef REG_ARB_STATS_EN
  logic grant_now;
  logic contend_now;

  assign grant_now   = (state == IDLE) && any_valid;
  assign contend_now = (state == IDLE) && bus.m0_valid && bus.m1_valid;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      m0_grant_cnt   <= '0;
      m1_grant_cnt   <= '0;
      contention_cnt <= '0;
    end else begin
      if (grant_now && !pick && (m0_grant_cnt != '1))
        m0_grant_cnt <= m0_grant_cnt + 16'd1;
      if (grant_now && pick && (m1_grant_cnt != '1))
        m1_grant_cnt <= m1_grant_cnt + 16'd1;
      if (contend_now && (contention_cnt != '1))
        contention_cnt <= contention_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb_reg_bus_arbiter: directed self-checking bench for reg_bus_arbiter
// (AW = DW = 8, RD_LAT = 1, MAX_LOCK = 16). The bank returns addr ^ 8'h7C
// one cycle after a read strobe.
module tb_reg_bus_arbiter;

  logic clk;
  logic resetb;
  int   checks;
  int   failures;
  int   grants[$];
  int   gcyc[$];

  reg_bus_arbiter_if #(.AW(8), .DW(8)) bus ();

`ifdef REG_ARB_STATS_EN
  logic [15:0] m0_grant_cnt;
  logic [15:0] m1_grant_cnt;
  logic [15:0] contention_cnt;
`endif

  reg_bus_arbiter #(
    .AW(8),
    .DW(8),
    .RD_LAT(1),
    .MAX_LOCK(16)
  ) dut (
    .clk(clk),
    .resetb(resetb),
    .bus(bus)
`ifdef REG_ARB_STATS_EN
    ,
    .m0_grant_cnt(m0_grant_cnt),
    .m1_grant_cnt(m1_grant_cnt),
    .contention_cnt(contention_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register bank with one cycle of read latency.
  initial bus.data_read_from_reg = '0;
  always @(posedge clk) begin
    if (bus.reg_en && !bus.write_en)
      bus.data_read_from_reg <= bus.address ^ 8'h7C;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.m0_valid = 1'b0; bus.m0_write = 1'b0; bus.m0_lock = 1'b0;
    bus.m0_addr  = '0;   bus.m0_wdata = '0;
    bus.m1_valid = 1'b0; bus.m1_write = 1'b0; bus.m1_lock = 1'b0;
    bus.m1_addr  = '0;   bus.m1_wdata = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_strobes"},
          {26'd0, bus.m0_ready, bus.m1_ready, bus.m0_rsp_valid, bus.m1_rsp_valid,
           bus.reg_en, bus.write_en}, 32'd0);
    check({tag, "_data"},
          {bus.address, bus.data_write_to_reg, bus.m0_rdata, bus.m1_rdata}, 32'd0);
  endtask

  task automatic reset_dut();
    clear_inputs();
    resetb = 1'b0;
    repeat (2) @(negedge clk);
    resetb = 1'b1;
    @(negedge clk);
  endtask

  // Single read on one port; checks the bank strobe, then rsp_valid exactly
  // three cycles after ready with the bank value.
  task automatic do_read(input logic p, input logic [7:0] a, input logic [7:0] exp,
                         input string tag);
    int   n;
    logic seen;
    if (p) begin bus.m1_valid = 1'b1; bus.m1_write = 1'b0; bus.m1_addr = a; end
    else   begin bus.m0_valid = 1'b1; bus.m0_write = 1'b0; bus.m0_addr = a; end
    n = 0;
    seen = 1'b0;
    while (!seen && n < 10) begin
      @(negedge clk);
      n++;
      seen = p ? bus.m1_ready : bus.m0_ready;
    end
    check({tag, "_ready"}, {31'd0, seen}, 32'd1);
    bus.m0_valid = 1'b0;
    bus.m1_valid = 1'b0;
    @(negedge clk);
    check({tag, "_bank"}, {22'd0, bus.reg_en, bus.write_en, bus.address}, {22'd0, 2'b10, a});
    @(negedge clk);
    check({tag, "_rsp_early"}, {30'd0, bus.m0_rsp_valid, bus.m1_rsp_valid}, 32'd0);
    @(negedge clk);
    if (p) check({tag, "_rsp"}, {23'd0, bus.m1_rsp_valid, bus.m1_rdata}, {23'd0, 1'b1, exp});
    else   check({tag, "_rsp"}, {23'd0, bus.m0_rsp_valid, bus.m0_rdata}, {23'd0, 1'b1, exp});
    @(negedge clk);
    if (p) check({tag, "_hold"}, {23'd0, bus.m1_rsp_valid, bus.m1_rdata}, {23'd0, 1'b0, exp});
    else   check({tag, "_hold"}, {23'd0, bus.m0_rsp_valid, bus.m0_rdata}, {23'd0, 1'b0, exp});
  endtask

  // Both masters issue queued writes; records which port got each ready and
  // in which cycle.
  task automatic run_masters(input int n0, input int n1, input logic lk0, input int max_cyc);
    int i0;
    int i1;
    int cyc;
    i0 = 0;
    i1 = 0;
    cyc = 0;
    grants.delete();
    gcyc.delete();
    bus.m0_lock = lk0;
    while ((i0 < n0 || i1 < n1) && cyc < max_cyc) begin
      bus.m0_valid = (i0 < n0); bus.m0_write = 1'b1;
      bus.m0_addr  = 8'(i0);    bus.m0_wdata = 8'(i0 + 1);
      bus.m1_valid = (i1 < n1); bus.m1_write = 1'b1;
      bus.m1_addr  = 8'(8'h80 + i1); bus.m1_wdata = 8'(8'hC0 + i1);
      @(negedge clk);
      cyc++;
      if (bus.m0_ready) begin grants.push_back(0); gcyc.push_back(cyc); i0++; end
      if (bus.m1_ready) begin grants.push_back(1); gcyc.push_back(cyc); i1++; end
    end
    clear_inputs();
    check("run_done", 32'(i0 + i1), 32'(n0 + n1));
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [31:0] exp;
    logic [31:0] got;
    int          rsp_seen;
    checks   = 0;
    failures = 0;
    clear_inputs();
    resetb = 1'b0;

    // Reset state
    reset_dut();
    check_all_zero("reset");

    // Single write on port 0
    bus.m0_valid = 1'b1; bus.m0_write = 1'b1; bus.m0_addr = 8'h12; bus.m0_wdata = 8'hA5;
    @(negedge clk);
    check("wr_ready", {29'd0, bus.m0_ready, bus.m1_ready, bus.reg_en}, {29'd0, 3'b100});
    bus.m0_valid = 1'b0;
    @(negedge clk);
    check("wr_bank", {14'd0, bus.reg_en, bus.write_en, bus.address, bus.data_write_to_reg},
          {14'd0, 2'b11, 8'h12, 8'hA5});
    @(negedge clk);
    check("wr_after", {29'd0, bus.reg_en, bus.m0_rsp_valid, bus.m1_rsp_valid}, 32'd0);
    check("wr_addr_hold", {24'd0, bus.address}, 32'h12);

    // Single read on port 1
    do_read(1'b1, 8'h40, 8'h3C, "rd1");

    // Alternation without lock
    reset_dut();
    run_masters(4, 4, 1'b0, 40);
    for (int i = 0; i < 8; i++) begin
      got = (i < grants.size()) ? 32'(grants[i]) : 32'hFFFF;
      check($sformatf("alt_seq[%0d]", i), got, 32'(i % 2));
    end
    for (int i = 1; i < 8; i++) begin
      got = (i < gcyc.size()) ? 32'(gcyc[i] - gcyc[i-1]) : 32'hFFFF;
      check($sformatf("alt_gap[%0d]", i), got, 32'd2);
    end

    // Lock: 17 port-0 grants, one port-1 grant, port 0 resumes locked
    reset_dut();
    run_masters(20, 5, 1'b1, 120);
    for (int i = 0; i < 25; i++) begin
      if (i < 17)      exp = 32'd0;
      else if (i == 17) exp = 32'd1;
      else if (i < 21) exp = 32'd0;
      else             exp = 32'd1;
      got = (i < grants.size()) ? 32'(grants[i]) : 32'hFFFF;
      check($sformatf("lock_seq[%0d]", i), got, exp);
    end

    // Reset in the middle of a port-0 read
    reset_dut();
    do_read(1'b0, 8'h40, 8'h3C, "rd0");
    bus.m0_valid = 1'b1; bus.m0_write = 1'b0; bus.m0_addr = 8'h55;
    @(negedge clk);
    check("abort_ready", {31'd0, bus.m0_ready}, 32'd1);
    bus.m0_valid = 1'b0;
    @(negedge clk);
    check("abort_issue", {30'd0, bus.reg_en, bus.write_en}, 32'h2);
    #2 resetb = 1'b0;
    #1 check_all_zero("abort_rst");
    repeat (2) @(negedge clk);
    resetb = 1'b1;
    rsp_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.m0_rsp_valid || bus.m0_ready || bus.reg_en) rsp_seen++;
    end
    check("abort_quiet", 32'(rsp_seen), 32'd0);
    do_read(1'b0, 8'h55, 8'h29, "rd_after");

`ifdef REG_ARB_STATS_EN
    reset_dut();
    run_masters(3, 1, 1'b0, 40);
    run_masters(2, 0, 1'b0, 40);
    run_masters(0, 2, 1'b0, 40);
    check("stat_m0", {16'd0, m0_grant_cnt}, 32'd5);
    check("stat_m1", {16'd0, m1_grant_cnt}, 32'd3);
    check("stat_cont", {16'd0, contention_cnt}, 32'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
